// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the execute-stage branch/PC unit: branch funct3
// encodings, the flush FSM state type and the sequential fetch step.
package pc_branch_unit_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pc_branch_unit_branch_decide.sv
// Combinational branch condition decode: turns funct3 plus the comparator
// flags into a taken decision, flags reserved encodings, and tells the
// comparator whether to compare unsigned.
module pc_branch_unit_branch_decide
    import pc_branch_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    output logic       br_un,
    output logic       taken,
    output logic       ill_branch
);

    // Unsigned compare is selected by funct3[1] (BLTU/BGEU); no latency.
    assign br_un = funct3[1];

    // Taken/illegal decode of the branch condition.
    always_comb begin
        taken      = 1'b0;
        ill_branch = 1'b0;
        case (funct3)
            FUNCT3_BEQ:  taken = br_eq;
            FUNCT3_BNE:  taken = ~br_eq;
            FUNCT3_BLT,
            FUNCT3_BLTU: taken = br_lt;
            FUNCT3_BGE,
            FUNCT3_BGEU: taken = ~br_lt;
            default:     ill_branch = 1'b1;   // 010/011 are reserved
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Execute-stage branch resolution and fetch PC generation. Holds the
// architectural PC, a RUN/FLUSH state machine that keeps the front-end
// flush asserted for FLUSH_CYCLES cycles per redirect, and branch
// performance counters.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_PC     = '0,
    parameter logic [XLEN-1:0]   TRAP_VEC     = XLEN'(4),
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_target,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            br_un,
    output logic [XLEN-1:0] pc,
    output logic            flush,
    output logic            misalign_exc,
    output logic            ill_branch,
    output logic [31:0]     br_count,
    output logic [31:0]     taken_count
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  STEP     = XLEN'(PC_STEP);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]  pc_nxt;

    logic             dec_taken;
    logic             dec_ill;
    logic             active;
    logic             br_taken;
    logic             redirect;
    logic [XLEN-1:0]  final_target;
    logic             br_counted;

    pc_branch_unit_branch_decide u_decide (
        .funct3     (ex_funct3),
        .br_eq      (br_eq),
        .br_lt      (br_lt),
        .br_un      (br_un),
        .taken      (dec_taken),
        .ill_branch (dec_ill)
    );

    // Redirect qualification and target selection (jalr > jal > branch).
    always_comb begin
        active       = ex_valid & (state == RUN);
        br_taken     = ex_is_branch & dec_taken & ~dec_ill;
        redirect     = active & (br_taken | ex_is_jal | ex_is_jalr);
        final_target = ex_target;
        if (ex_is_jalr) begin
            final_target = {ex_target[XLEN-1:1], 1'b0};
        end
        misalign_exc = redirect & (final_target[1:0] != 2'b00);
        ill_branch   = ex_valid & ex_is_branch & dec_ill;
        br_counted   = active & ex_is_branch & ~dec_ill;
    end

    // Next-state, next-PC, flush counter and flush output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush  = 1'b1;
                    pc_nxt = misalign_exc ? TRAP_VEC : final_target;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = FLUSH;
                    end
                end else if (!stall) begin
                    pc_nxt = pc + STEP;
                end
            end
            FLUSH: begin
                // Fetch keeps advancing from the new target; only the
                // front-end contents are being killed.
                flush = 1'b1;
                if (!stall) begin
                    pc_nxt  = pc + STEP;
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // PC, FSM state and flush counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pc    <= pc_nxt;
        end
    end

    // Branch performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (br_counted) begin
            br_count <= br_count + 32'd1;
            if (dec_taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: sequential fetch, branch/JAL/JALR
// redirects, misaligned trap, stall interaction, flush length and reset.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_target;
    logic        br_eq;
    logic        br_lt;
    logic        br_un;
    logic [31:0] pc;
    logic        flush;
    logic        misalign_exc;
    logic        ill_branch;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    int n_assert = 0;
    int n_fail   = 0;

    pc_branch_unit #(
        .XLEN         (32),
        .RESET_PC     (32'h0),
        .TRAP_VEC     (32'h4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_is_jal    (ex_is_jal),
        .ex_is_jalr   (ex_is_jalr),
        .ex_funct3    (ex_funct3),
        .ex_target    (ex_target),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .br_un        (br_un),
        .pc           (pc),
        .flush        (flush),
        .misalign_exc (misalign_exc),
        .ill_branch   (ill_branch),
        .br_count     (br_count),
        .taken_count  (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
        ex_funct3    = 3'b000;
        ex_target    = 32'h0;
        br_eq        = 1'b0;
        br_lt        = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic eq, input logic lt, input logic [31:0] tgt);
        clear_ex();
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_funct3    = f3;
        br_eq        = eq;
        br_lt        = lt;
        ex_target    = tgt;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        clear_ex();
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_brcnt", br_count, 32'h0);
        chk("rst_tkcnt", taken_count, 32'h0);

        // Idle sequential fetch
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); chk("seq_pc12", pc, 32'hc);
        chk("seq_flush", {31'b0, flush}, 32'h0);

        // BEQ taken -> redirect to 0x100, flush two cycles
        branch(3'b000, 1'b1, 1'b0, 32'h100);
        #1;
        chk("beq_flush0", {31'b0, flush}, 32'h1);
        chk("beq_brun", {31'b0, br_un}, 32'h0);
        tick(); clear_ex(); #1;
        chk("beq_pc", pc, 32'h100);
        chk("beq_flush1", {31'b0, flush}, 32'h1);
        chk("beq_brcnt", br_count, 32'h1);
        chk("beq_tkcnt", taken_count, 32'h1);
        tick();
        chk("beq_pc_after", pc, 32'h104);
        chk("beq_flush2", {31'b0, flush}, 32'h0);

        // BLTU not taken -> unsigned compare, sequential pc, br_count only
        branch(3'b110, 1'b0, 1'b0, 32'h300);
        #1;
        chk("bltu_brun", {31'b0, br_un}, 32'h1);
        chk("bltu_flush", {31'b0, flush}, 32'h0);
        tick(); clear_ex(); #1;
        chk("bltu_pc", pc, 32'h108);
        chk("bltu_brcnt", br_count, 32'h2);
        chk("bltu_tkcnt", taken_count, 32'h1);

        // JALR clears target bit 0
        ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_target = 32'h201;
        #1;
        chk("jalr_flush", {31'b0, flush}, 32'h1);
        chk("jalr_misal", {31'b0, misalign_exc}, 32'h0);
        tick(); clear_ex(); #1;
        chk("jalr_pc", pc, 32'h200);
        tick();
        chk("jalr_pc_after", pc, 32'h204);

        // JAL to a misaligned target traps
        ex_valid = 1'b1; ex_is_jal = 1'b1; ex_target = 32'h102;
        #1;
        chk("jal_misal", {31'b0, misalign_exc}, 32'h1);
        tick(); clear_ex(); #1;
        chk("jal_trap_pc", pc, 32'h4);
        chk("jal_brcnt", br_count, 32'h2);
        tick();
        chk("jal_pc_after", pc, 32'h8);

        // BNE taken while stalled: redirect still wins
        stall = 1'b1;
        branch(3'b001, 1'b0, 1'b0, 32'h400);
        #1;
        chk("stall_redir_flush", {31'b0, flush}, 32'h1);
        tick();
        // In FLUSH, a valid taken branch in EX must be ignored
        branch(3'b000, 1'b1, 1'b0, 32'h500);
        #1;
        chk("stall_redir_pc", pc, 32'h400);
        chk("stall_brcnt", br_count, 32'h3);
        chk("stall_tkcnt", taken_count, 32'h2);
        chk("flush_ign_misal", {31'b0, misalign_exc}, 32'h0);
        tick();
        chk("flush_stall1_flush", {31'b0, flush}, 32'h1);
        chk("flush_stall1_pc", pc, 32'h400);
        tick();
        chk("flush_stall2_flush", {31'b0, flush}, 32'h1);
        chk("flush_ign_brcnt", br_count, 32'h3);
        stall = 1'b0;
        tick(); clear_ex(); #1;
        chk("flush_end_pc", pc, 32'h404);
        chk("flush_end_flush", {31'b0, flush}, 32'h0);
        chk("flush_ign_tkcnt", taken_count, 32'h2);

        // BGE taken (not less-than) then reset in the middle of FLUSH
        branch(3'b101, 1'b0, 1'b0, 32'h600);
        #1;
        chk("bge_brun", {31'b0, br_un}, 32'h0);
        tick(); clear_ex(); #1;
        chk("bge_pc", pc, 32'h600);
        chk("bge_tkcnt", taken_count, 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_flush", {31'b0, flush}, 32'h0);
        chk("midrst_brcnt", br_count, 32'h0);
        chk("midrst_tkcnt", taken_count, 32'h0);

        // Reserved funct3 010: illegal, not taken, not counted
        branch(3'b010, 1'b1, 1'b1, 32'h700);
        #1;
        chk("ill_flag", {31'b0, ill_branch}, 32'h1);
        chk("ill_flush", {31'b0, flush}, 32'h0);
        tick(); clear_ex(); #1;
        chk("ill_pc", pc, 32'h4);
        chk("ill_brcnt", br_count, 32'h0);
        chk("ill_clear", {31'b0, ill_branch}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
